bp_cce_split_sequencer: RTL and testbench
=========================================

# bp_cce_split_sequencer

Serializing controller between the BlackParrot CCE I/O memory port and a single 32-bit manycore-side memory port. Accepts one BedRock cce mem command (up to 64-bit), issues it as one or two 32-bit split commands back-to-back on one split port, collects the split responses in order, and returns one reassembled cce response. Only one command is in flight at a time. It replaces the lockstep two-port fan-out wherever only one 32-bit endpoint is available.

## Interface
Parameters:
- bp_params_p, e_bp_default_cfg, processor config; sets paddr_width_p, dword_width_p (64), word_width_p (32), lce_id_width_p, lce_assoc_p.
- Derived: cce_mem_msg_width_lp (dword-data BedRock mem msg); split_mem_msg_width_lp (word-data BedRock mem msg).

Ports:
- clk_i  in  1  sole clock.
- reset_i  in  1  asynchronous, active-high reset.
- io_cmd_i  in  cce_mem_msg_width_lp  incoming command.
- io_cmd_v_i  in  1  command valid.
- io_cmd_ready_o  out  1  ready-valid acceptance.
- io_resp_o  out  cce_mem_msg_width_lp  reassembled response.
- io_resp_v_o  out  1  response valid.
- io_resp_yumi_i  in  1  consumer takes response.
- io_cmd_o  out  split_mem_msg_width_lp  split command.
- io_cmd_v_o  out  1  split command valid.
- io_cmd_ready_i  in  1  split port ready.
- io_resp_i  in  split_mem_msg_width_lp  split response.
- io_resp_v_i  in  1  split response valid.
- io_resp_yumi_o  out  1  split response consumed.

## Operation
- State machine: e_idle, e_send, e_wait, e_resp. Registers: latched header, 64-bit cmd data, piece index idx (1 bit), last index (1 bit), 64-bit response data.
- e_idle: io_cmd_ready_o=1. On io_cmd_v_i: latch header and data; last=1 if header.size==e_bedrock_msg_size_8, else 0; idx=0; clear response data; -> e_send.
- e_send: io_cmd_v_o=1. io_cmd_o = latched header with size=e_bedrock_msg_size_4 if last=1, else the original size; addr = latched addr + 4*idx (paddr_width_p wide, modulo wrap); data = latched data[32*idx +: 32]. On io_cmd_ready_i -> e_wait.
- e_wait: io_resp_yumi_o = io_resp_v_i. On io_resp_v_i: write io_resp_i.data[31:0] into response data[32*idx +: 32]. If idx==last -> e_resp, else idx=idx+1 -> e_send.
- e_resp: io_resp_v_o=1. io_resp_o = latched header (original size, addr, msg_type, payload) with data = {hi, lo}; hi is 0 for single-piece commands. On io_resp_yumi_i -> e_idle.
- Split response header is ignored; only data is used. Read and write commands are sequenced identically; for writes the returned data is don't-care but is still passed through.
- Sizes 16 B and above are unsupported. Simulation-only assertion on accept: $error "Only <=64-bit commands supported". RTL then treats the command as 64-bit.

## Timing
- Reset (async assert, sync release): state=e_idle, idx=0, last=0, all data/header registers 0. Outputs: io_cmd_ready_o=1, io_cmd_v_o=0, io_resp_v_o=0, io_resp_yumi_o=0, io_resp_o=0, io_cmd_o=0.
- All valid and ready outputs are decoded from registered state only. io_resp_yumi_o is the exception: it equals io_resp_v_i while in e_wait. No combinational path from io_cmd_v_i to io_cmd_v_o.
- Minimum latency with split port always ready and zero-delay responses:
  - 64-bit command: accept at cycle 0; piece0 cmd cycle 1; resp0 cycle 2; piece1 cmd cycle 3; resp1 cycle 4; io_resp_v_o cycle 5.
  - ≤32-bit command: io_resp_v_o at cycle 3.
- io_cmd_ready_o=0 from the cycle after accept until the cycle after io_resp_yumi_i.
- io_cmd_v_o is held with stable io_cmd_o until io_cmd_ready_i. io_resp_v_o is held with stable io_resp_o until io_resp_yumi_i.
- io_resp_v_i outside e_wait is a protocol violation: not consumed (yumi=0), and a simulation assertion fires.
- Response in the same cycle the command is issued cannot occur, since e_wait is entered only after the cmd handshake.
- Reset mid-operation: the in-flight command is dropped; responses arriving after release are never consumed.

## Test plan
- 64-bit read, addr 0x8000_0000, split port always ready, responses 0x1111_1111 then 0x2222_2222 -> two split cmds: size 4, addrs 0x8000_0000 / 0x8000_0004; one response with data 0x2222_2222_1111_1111 and size 8 at cycle 5.
- 64-bit write, data 0xDEAD_BEEF_CAFE_F00D -> split data 0xCAFE_F00D then 0xDEAD_BEEF, in that order; one cce response returned.
- 4-byte read, addr 0x100, response 0xABCD_0123 -> exactly one split cmd with size 4; response data 0x0000_0000_ABCD_0123 at cycle 3.
- Backpressure: io_cmd_ready_i low 3 cycles and io_resp_yumi_i low 4 cycles -> io_cmd_o and io_resp_o stable throughout; io_cmd_ready_o stays 0; no second command is accepted.
- Address wrap: 64-bit command at paddr max-3 (all-ones with low 3 bits 100) -> piece1 addr wraps to 0.
- Async reset asserted while in e_wait -> all outputs return to reset values immediately; the next command is handled normally.

Source files
------------

// File: rtl/bp_cce_split_sequencer.sv
// bp_cce_split_sequencer: serializes one <=64-bit BedRock mem command onto a single 32-bit
// split port, one piece at a time, and reassembles the split responses into one response.

module bp_cce_split_sequencer
  #(parameter int paddr_width_p   = 40
    , parameter int payload_width_p = 16
    , localparam int hdr_width_lp           = 11 + paddr_width_p + payload_width_p
    , localparam int cce_mem_msg_width_lp   = hdr_width_lp + 64
    , localparam int split_mem_msg_width_lp = hdr_width_lp + 32
  )
  ( input  logic                              clk_i
  , input  logic                              reset_i
  , input  logic [cce_mem_msg_width_lp-1:0]   io_cmd_i
  , input  logic                              io_cmd_v_i
  , output logic                              io_cmd_ready_o
  , output logic [cce_mem_msg_width_lp-1:0]   io_resp_o
  , output logic                              io_resp_v_o
  , input  logic                              io_resp_yumi_i
  , output logic [split_mem_msg_width_lp-1:0] io_cmd_o
  , output logic                              io_cmd_v_o
  , input  logic                              io_cmd_ready_i
  , input  logic [split_mem_msg_width_lp-1:0] io_resp_i
  , input  logic                              io_resp_v_i
  , output logic                              io_resp_yumi_o
  );

  // Header layout, LSB first: msg_type[3:0], subop[7:4], addr, size[2:0], payload
  localparam int addr_lsb_lp = 8;
  localparam int size_lsb_lp = 8 + paddr_width_p;
  localparam logic [2:0] size_4_lp = 3'd2;
  localparam logic [2:0] size_8_lp = 3'd3;

  typedef enum logic [1:0] {e_idle, e_send, e_wait, e_resp} state_e;

  state_e                    state_r, state_n_s;
  logic [hdr_width_lp-1:0]   hdr_r;
  logic [63:0]               data_r;
  logic                      idx_r;
  logic                      last_r;
  logic [63:0]               resp_data_r;
  logic [hdr_width_lp-1:0]   cmd_hdr_s;
  logic [paddr_width_p-1:0]  piece_off_s;
  logic [2:0]                in_size_s;
  logic [31:0]               resp_word_s;
  logic                      unused_s;

  assign in_size_s   = io_cmd_i[size_lsb_lp +: 3];
  assign resp_word_s = io_resp_i[hdr_width_lp +: 32];
  assign piece_off_s = {{(paddr_width_p-3){1'b0}}, idx_r, 2'b00};
  // Split response header carries nothing we need
  assign unused_s    = ^io_resp_i[hdr_width_lp-1:0];

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state and handshake decode; valids/readies depend on state_r only
  always_comb begin
    state_n_s      = state_r;
    io_cmd_ready_o = 1'b0;
    io_cmd_v_o     = 1'b0;
    io_resp_v_o    = 1'b0;
    io_resp_yumi_o = 1'b0;
    case (state_r)
      e_idle: begin
        io_cmd_ready_o = 1'b1;
        if (io_cmd_v_i) state_n_s = e_send;
        else            state_n_s = e_idle;
      end
      e_send: begin
        io_cmd_v_o = 1'b1;
        if (io_cmd_ready_i) state_n_s = e_wait;
        else                state_n_s = e_send;
      end
      e_wait: begin
        io_resp_yumi_o = io_resp_v_i;
        if (!io_resp_v_i)         state_n_s = e_wait;
        else if (idx_r == last_r) state_n_s = e_resp;
        else                      state_n_s = e_send;
      end
      e_resp: begin
        io_resp_v_o = 1'b1;
        if (io_resp_yumi_i) state_n_s = e_idle;
        else                state_n_s = e_resp;
      end
      default: state_n_s = e_idle;
    endcase
  end

  // Command latch, piece index and response reassembly
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hdr_r       <= '0;
      data_r      <= 64'h0;
      idx_r       <= 1'b0;
      last_r      <= 1'b0;
      resp_data_r <= 64'h0;
    end else begin
      case (state_r)
        e_idle: begin
          if (io_cmd_v_i) begin
            hdr_r       <= io_cmd_i[hdr_width_lp-1:0];
            data_r      <= io_cmd_i[hdr_width_lp +: 64];
            // Oversized commands are flagged by the checker and handled as 64-bit
            last_r      <= (in_size_s >= size_8_lp);
            idx_r       <= 1'b0;
            resp_data_r <= 64'h0;
          end
        end
        e_wait: begin
          if (io_resp_v_i) begin
            if (idx_r) resp_data_r[63:32] <= resp_word_s;
            else       resp_data_r[31:0]  <= resp_word_s;
            if (idx_r != last_r) idx_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Split command: pieces of a 64-bit command go out as size-4 at addr + 4*idx
  always_comb begin
    cmd_hdr_s = hdr_r;
    cmd_hdr_s[size_lsb_lp +: 3] = last_r ? size_4_lp : hdr_r[size_lsb_lp +: 3];
    cmd_hdr_s[addr_lsb_lp +: paddr_width_p] = hdr_r[addr_lsb_lp +: paddr_width_p] + piece_off_s;
  end

  assign io_cmd_o  = {(idx_r ? data_r[63:32] : data_r[31:0]), cmd_hdr_s};
  assign io_resp_o = {resp_data_r, hdr_r};

  bp_cce_split_sequencer_chk chk
    (.clk_i      (clk_i)
     ,.reset_i   (reset_i)
     ,.cmd_accept(io_cmd_v_i && (state_r == e_idle))
     ,.cmd_size  (in_size_s)
     ,.resp_v    (io_resp_v_i)
     ,.in_wait   (state_r == e_wait)
     );

endmodule

// Protocol checks for the split sequencer; simulation only.
module bp_cce_split_sequencer_chk
  ( input logic       clk_i
  , input logic       reset_i
  , input logic       cmd_accept
  , input logic [2:0] cmd_size
  , input logic       resp_v
  , input logic       in_wait
  );

  a_cmd_size: assert property (@(posedge clk_i) disable iff (reset_i)
    cmd_accept |-> (cmd_size <= 3'd3))
    else $error("Only <=64-bit commands supported");

  a_resp_in_wait: assert property (@(posedge clk_i) disable iff (reset_i)
    resp_v |-> in_wait)
    else $error("Split response received outside e_wait");

endmodule

// File: tb/tb_bp_cce_split_sequencer.sv
// Scoreboard bench for bp_cce_split_sequencer: expected split commands and cce responses are
// queued when a command is driven and compared whenever the DUT presents them.

module tb_bp_cce_split_sequencer;

  localparam int paddr_w = 40;
  localparam int pay_w   = 16;
  localparam int hdr_w   = 11 + paddr_w + pay_w;
  localparam int cce_w   = hdr_w + 64;
  localparam int spl_w   = hdr_w + 32;
  localparam int cw      = 160;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [cce_w-1:0] io_cmd_i = '0;
  logic             io_cmd_v_i = 1'b0;
  logic             io_cmd_ready_o;
  logic [cce_w-1:0] io_resp_o;
  logic             io_resp_v_o;
  logic             io_resp_yumi_i = 1'b0;
  logic [spl_w-1:0] io_cmd_o;
  logic             io_cmd_v_o;
  logic             io_cmd_ready_i = 1'b1;
  logic [spl_w-1:0] io_resp_i = '0;
  logic             io_resp_v_i = 1'b0;
  logic             io_resp_yumi_o;

  bp_cce_split_sequencer #(.paddr_width_p(paddr_w), .payload_width_p(pay_w)) dut
    (.clk_i          (clk)
     ,.reset_i       (rst)
     ,.io_cmd_i      (io_cmd_i)
     ,.io_cmd_v_i    (io_cmd_v_i)
     ,.io_cmd_ready_o(io_cmd_ready_o)
     ,.io_resp_o     (io_resp_o)
     ,.io_resp_v_o   (io_resp_v_o)
     ,.io_resp_yumi_i(io_resp_yumi_i)
     ,.io_cmd_o      (io_cmd_o)
     ,.io_cmd_v_o    (io_cmd_v_o)
     ,.io_cmd_ready_i(io_cmd_ready_i)
     ,.io_resp_i     (io_resp_i)
     ,.io_resp_v_i   (io_resp_v_i)
     ,.io_resp_yumi_o(io_resp_yumi_o)
     );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int cmd_stall = 0, yumi_stall = 0, rsp_delay = 0;
  int cmd_wait = 0, yumi_wait = 0, rsp_wait = 0;
  bit busy = 1'b0, resp_v_prev = 1'b0, rsp_pending = 1'b0;
  bit cmd_fire = 1'b0, rsp_fire = 1'b0, out_fire = 1'b0;

  logic [spl_w-1:0] exp_cmd_q[$];
  logic [cce_w-1:0] exp_resp_q[$];
  logic [31:0]      rsp_word_q[$];
  int               exp_lat_q[$];

  task automatic check_val(input string tag, input logic [cw-1:0] obs, input logic [cw-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [hdr_w-1:0] mk_hdr(input logic [3:0] mt, input logic [paddr_w-1:0] a,
                                              input logic [2:0] sz, input logic [pay_w-1:0] pl);
    return {pl, sz, a, 4'h5, mt};
  endfunction

  task automatic check_reset_outputs(input string where);
    check_val({where, "_cmd_ready"}, cw'(io_cmd_ready_o), cw'(1'b1));
    check_val({where, "_cmd_v"},     cw'(io_cmd_v_o),     cw'(1'b0));
    check_val({where, "_resp_v"},    cw'(io_resp_v_o),    cw'(1'b0));
    check_val({where, "_resp_yumi"}, cw'(io_resp_yumi_o), cw'(1'b0));
    check_val({where, "_resp"},      cw'(io_resp_o),      cw'(0));
    check_val({where, "_cmd"},       cw'(io_cmd_o),       cw'(0));
  endtask

  // Queue expectations, then drive the command until accepted
  task automatic issue(input logic [3:0] mt, input logic [paddr_w-1:0] a, input logic [2:0] sz,
                       input logic [63:0] d, input logic [31:0] w0, input logic [31:0] w1,
                       input int lat);
    logic [hdr_w-1:0]   h;
    logic [pay_w-1:0]   pl;
    logic [paddr_w-1:0] a1;
    bit two;
    int guard;
    pl  = pay_w'($urandom);
    two = (sz == 3'd3);
    h   = mk_hdr(mt, a, sz, pl);
    a1  = a + paddr_w'(4);
    exp_cmd_q.push_back({d[31:0], mk_hdr(mt, a, two ? 3'd2 : sz, pl)});
    rsp_word_q.push_back(w0);
    if (two) begin
      exp_cmd_q.push_back({d[63:32], mk_hdr(mt, a1, 3'd2, pl)});
      rsp_word_q.push_back(w1);
    end
    exp_resp_q.push_back({(two ? w1 : 32'h0), w0, h});
    exp_lat_q.push_back(lat);
    @(posedge clk); #1;
    io_cmd_i   = {d, h};
    io_cmd_v_i = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!io_cmd_ready_o && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    check_val("cmd_accepted", cw'(io_cmd_ready_o), cw'(1'b1));
    @(posedge clk); #1;
    io_cmd_v_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_resp_q.size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check_val("drain_resp_left", cw'(exp_resp_q.size()), cw'(0));
    check_val("drain_cmd_left",  cw'(exp_cmd_q.size()),  cw'(0));
  endtask

  // Cycle count plus split-port responder and cce-side consumer, driven just after each edge
  initial forever begin
    logic [95:0] junk;
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      io_resp_v_i    = 1'b0;
      rsp_pending    = 1'b0;
      io_cmd_ready_i = (cmd_stall == 0);
      io_resp_yumi_i = 1'b0;
    end else begin
      if (rsp_fire) begin
        io_resp_v_i = 1'b0;
        rsp_pending = 1'b0;
        if (rsp_word_q.size() > 0) void'(rsp_word_q.pop_front());
      end
      if (cmd_fire) begin
        rsp_pending = 1'b1;
        rsp_wait    = rsp_delay;
      end
      if (rsp_pending && !io_resp_v_i) begin
        if (rsp_wait > 0) rsp_wait--;
        else if (rsp_word_q.size() > 0) begin
          junk        = {$urandom, $urandom, $urandom};
          io_resp_i   = {rsp_word_q[0], junk[hdr_w-1:0]};
          io_resp_v_i = 1'b1;
        end
      end
      if (io_cmd_v_o) begin
        if (cmd_wait > 0) begin
          io_cmd_ready_i = 1'b0;
          cmd_wait--;
        end else io_cmd_ready_i = 1'b1;
      end else begin
        cmd_wait       = cmd_stall;
        io_cmd_ready_i = (cmd_stall == 0);
      end
      if (out_fire) io_resp_yumi_i = 1'b0;
      else if (io_resp_v_o) begin
        if (yumi_wait > 0) begin
          yumi_wait--;
          io_resp_yumi_i = 1'b0;
        end else io_resp_yumi_i = 1'b1;
      end else begin
        io_resp_yumi_i = 1'b0;
        yumi_wait      = yumi_stall;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard on the falling edge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      busy = 1'b0; resp_v_prev = 1'b0;
      cmd_fire = 1'b0; rsp_fire = 1'b0; out_fire = 1'b0;
    end else begin
      if (busy) check_val("cmd_ready_while_busy", cw'(io_cmd_ready_o), cw'(1'b0));
      check_val("split_yumi", cw'(io_resp_yumi_o), cw'(io_resp_v_i));
      cmd_fire = io_cmd_v_o && io_cmd_ready_i;
      if (io_cmd_v_o) begin
        if (exp_cmd_q.size() == 0) check_val("unexpected_split_cmd", cw'(io_cmd_v_o), cw'(1'b0));
        else begin
          check_val("split_cmd", cw'(io_cmd_o), cw'(exp_cmd_q[0]));
          if (cmd_fire) void'(exp_cmd_q.pop_front());
        end
      end
      rsp_fire = io_resp_v_i && io_resp_yumi_o;
      out_fire = io_resp_v_o && io_resp_yumi_i;
      if (io_resp_v_o) begin
        if (exp_resp_q.size() == 0) check_val("unexpected_cce_resp", cw'(io_resp_v_o), cw'(1'b0));
        else begin
          if (!resp_v_prev && exp_lat_q[0] >= 0)
            check_val("resp_latency", cw'(cyc - acc_cyc), cw'(exp_lat_q[0]));
          check_val("cce_resp", cw'(io_resp_o), cw'(exp_resp_q[0]));
          if (out_fire) begin
            void'(exp_resp_q.pop_front());
            void'(exp_lat_q.pop_front());
            busy = 1'b0;
          end
        end
      end
      if (io_cmd_v_i && io_cmd_ready_o) begin
        busy    = 1'b1;
        acc_cyc = cyc;
      end
      resp_v_prev = io_resp_v_o;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [2:0]  sz;
    int          lat;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 64-bit read
    issue(4'h0, 40'h00_8000_0000, 3'd3, 64'h0, 32'h1111_1111, 32'h2222_2222, 5);
    drain();
    // 64-bit write: low word goes out first
    issue(4'h1, 40'h00_8000_0040, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 32'h0BAD_F00D, 32'h1234_5678, 5);
    drain();
    // 4-byte and 1-byte reads
    issue(4'h0, 40'h00_0000_0100, 3'd2, 64'h0, 32'hABCD_0123, 32'h0, 3);
    drain();
    issue(4'h0, 40'h00_0000_0203, 3'd0, 64'h0, 32'h0000_00A5, 32'h0, 3);
    drain();

    // Backpressure on both sides, with a second command waiting behind the first
    cmd_stall  = 3;
    yumi_stall = 4;
    issue(4'h1, 40'h00_4000_0000, 3'd3, 64'h0102_0304_0506_0708, 32'hAAAA_0001, 32'hAAAA_0002, -1);
    issue(4'h0, 40'h00_4000_0010, 3'd2, 64'h0, 32'hBBBB_0003, 32'h0, -1);
    drain();
    cmd_stall  = 0;
    yumi_stall = 0;

    // Address wrap on the second piece
    issue(4'h0, 40'hFF_FFFF_FFFC, 3'd3, 64'h0, 32'h5555_AAAA, 32'hAAAA_5555, 5);
    drain();

    // Reset while the split response is outstanding
    rsp_delay = 6;
    issue(4'h0, 40'h00_1000_0000, 3'd3, 64'h0, 32'hDEAD_0000, 32'hDEAD_0001, -1);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    io_resp_v_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_cmd_q.delete();
    exp_resp_q.delete();
    rsp_word_q.delete();
    exp_lat_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rsp_delay = 0;
    issue(4'h0, 40'h00_1000_0008, 3'd3, 64'h0, 32'h7777_0000, 32'h7777_0001, 5);
    drain();

    // Randomized mix of sizes, stalls and response delays
    for (int i = 0; i < 8; i++) begin
      sz         = 3'($urandom_range(0, 3));
      d          = {$urandom, $urandom};
      cmd_stall  = $urandom_range(0, 2);
      yumi_stall = $urandom_range(0, 2);
      rsp_delay  = $urandom_range(0, 2);
      lat = (cmd_stall == 0 && yumi_stall == 0 && rsp_delay == 0) ? ((sz == 3'd3) ? 5 : 3) : -1;
      issue(4'($urandom_range(0, 1)), {8'h00, $urandom}, sz, d, $urandom, $urandom, lat);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
